// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// the default divide occupancy and the register-index width.
package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_DIV = 1'b1
  } hz_state_e;

  localparam int unsigned DIV_CYCLES_DEF = 16;
  localparam int unsigned REG_IDX_W      = 5;

endpackage

// File: rtl/pipe_hazard_ctrl_lu_detect.sv
// Combinational load-use comparator: flags when the instruction in ID reads
// the destination of a load ahead of it (r0 never creates a dependency).
module hazard_lu_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic                 ex_valid,
  input  logic                 ex_is_load,
  input  logic [REG_IDX_W-1:0] ex_reg_d,
  input  logic [REG_IDX_W-1:0] id_reg_j,
  input  logic [REG_IDX_W-1:0] id_reg_k,
  input  logic [REG_IDX_W-1:0] id_reg_d,
  input  logic                 id_reg_j_ren,
  input  logic                 id_reg_k_ren,
  input  logic                 id_reg_d_ren,
  output logic                 lu
);

  logic src_hit;

  always_comb begin
    src_hit = (id_reg_j_ren && (id_reg_j == ex_reg_d)) ||
              (id_reg_k_ren && (id_reg_k == ex_reg_d)) ||
              (id_reg_d_ren && (id_reg_d == ex_reg_d));
    lu      = ex_valid && ex_is_load && (ex_reg_d != '0) && src_hit;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, divide/memory freeze,
// mispredict flush and deferred branch-prediction clear for ID/EX.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W      = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] id_reg_j,
  input  logic [REG_IDX_W-1:0] id_reg_k,
  input  logic [REG_IDX_W-1:0] id_reg_d,
  input  logic                 id_reg_j_ren,
  input  logic                 id_reg_k_ren,
  input  logic                 id_reg_d_ren,
  input  logic                 ex_valid,
  input  logic                 ex_is_load,
  input  logic [REG_IDX_W-1:0] ex_reg_d,
  input  logic                 ex_div_start,
  input  logic                 ex_br_mispredict,
  input  logic                 mem_busy,
  input  logic                 bpu_invalidate,
  output logic                 pc_wen,
  output logic                 if_id_wen,
  output logic                 if_id_flush,
  output logic                 id_ex_wen,
  output logic                 id_ex_flush,
  output logic                 id_ex_bp_flush,
  output logic                 div_busy,
  output logic [15:0]          stall_cycles
);

  hz_state_e        state, state_nxt;
  logic [CNT_W-1:0] div_cnt, div_cnt_nxt;
  logic             flush_pend, flush_pend_nxt;
  logic             bp_pend, bp_pend_nxt;
  logic             lu, div_go, freeze;
  logic             pc_wen_c, if_id_wen_c, if_id_flush_c, id_ex_wen_c, id_ex_flush_c;

  hazard_lu_detect u_lu (
    .ex_valid     (ex_valid),
    .ex_is_load   (ex_is_load),
    .ex_reg_d     (ex_reg_d),
    .id_reg_j     (id_reg_j),
    .id_reg_k     (id_reg_k),
    .id_reg_d     (id_reg_d),
    .id_reg_j_ren (id_reg_j_ren),
    .id_reg_k_ren (id_reg_k_ren),
    .id_reg_d_ren (id_reg_d_ren),
    .lu           (lu)
  );

  always_comb begin
    state_nxt      = state;
    div_cnt_nxt    = div_cnt;
    pc_wen_c       = 1'b0;
    if_id_wen_c    = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_wen_c    = 1'b0;
    id_ex_flush_c  = 1'b0;

    // A divide start accepted in RUN freezes its own cycle too.
    div_go = (state == ST_RUN) && ex_div_start && !mem_busy;
    freeze = mem_busy || (state == ST_DIV) || div_go;

    case (state)
      ST_RUN: begin
        if (div_go) begin
          state_nxt   = ST_DIV;
          div_cnt_nxt = CNT_W'(DIV_CYCLES - 2);
        end
      end
      ST_DIV: begin
        if (!mem_busy) begin
          if (div_cnt == '0) state_nxt = ST_RUN;
          else               div_cnt_nxt = div_cnt - 1'b1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase

    if (!freeze) begin
      if (ex_br_mispredict || flush_pend) begin
        pc_wen_c      = 1'b1;
        if_id_wen_c   = 1'b1;
        if_id_flush_c = 1'b1;
        id_ex_wen_c   = 1'b1;
        id_ex_flush_c = 1'b1;
      end else if (lu) begin
        id_ex_wen_c   = 1'b1;
        id_ex_flush_c = 1'b1;
      end else begin
        pc_wen_c      = 1'b1;
        if_id_wen_c   = 1'b1;
        id_ex_wen_c   = 1'b1;
      end
    end

    flush_pend_nxt = freeze && (flush_pend || ex_br_mispredict);
    bp_pend_nxt    = bpu_invalidate || (bp_pend && !id_ex_wen_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RUN;
      div_cnt      <= '0;
      flush_pend   <= 1'b0;
      bp_pend      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state        <= state_nxt;
      div_cnt      <= div_cnt_nxt;
      flush_pend   <= flush_pend_nxt;
      bp_pend      <= bp_pend_nxt;
      if (freeze && (stall_cycles != '1)) stall_cycles <= stall_cycles + 16'd1;
    end
  end

  // Controls are combinational from registered state, so gate them while in reset.
  assign pc_wen         = rst_n && pc_wen_c;
  assign if_id_wen      = rst_n && if_id_wen_c;
  assign if_id_flush    = rst_n && if_id_flush_c;
  assign id_ex_wen      = rst_n && id_ex_wen_c;
  assign id_ex_flush    = rst_n && id_ex_flush_c;
  assign id_ex_bp_flush = bp_pend;
  assign div_busy       = (state == ST_DIV);

  a_no_mispredict_with_div: assert property (
    @(posedge clk) disable iff (!rst_n) !(ex_br_mispredict && ex_div_start));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: each task drives one scenario and
// checks the control outputs against hand-derived values.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_reg_j, id_reg_k, id_reg_d, ex_reg_d;
  logic       id_reg_j_ren, id_reg_k_ren, id_reg_d_ren;
  logic       ex_valid, ex_is_load, ex_div_start, ex_br_mispredict;
  logic       mem_busy, bpu_invalidate;
  logic       pc_wen, if_id_wen, if_id_flush, id_ex_wen, id_ex_flush;
  logic       id_ex_bp_flush, div_busy;
  logic [15:0] stall_cycles;
  logic [4:0] ctl;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // ctl = {pc_wen, if_id_wen, if_id_flush, id_ex_wen, id_ex_flush}
  localparam logic [4:0] C_RUN    = 5'b11010;
  localparam logic [4:0] C_BUBBLE = 5'b00011;
  localparam logic [4:0] C_FLUSH  = 5'b11111;
  localparam logic [4:0] C_FROZEN = 5'b00000;

  assign ctl = {pc_wen, if_id_wen, if_id_flush, id_ex_wen, id_ex_flush};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DIV_CYCLES(16), .CNT_W(5)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_reg_j         (id_reg_j),
    .id_reg_k         (id_reg_k),
    .id_reg_d         (id_reg_d),
    .id_reg_j_ren     (id_reg_j_ren),
    .id_reg_k_ren     (id_reg_k_ren),
    .id_reg_d_ren     (id_reg_d_ren),
    .ex_valid         (ex_valid),
    .ex_is_load       (ex_is_load),
    .ex_reg_d         (ex_reg_d),
    .ex_div_start     (ex_div_start),
    .ex_br_mispredict (ex_br_mispredict),
    .mem_busy         (mem_busy),
    .bpu_invalidate   (bpu_invalidate),
    .pc_wen           (pc_wen),
    .if_id_wen        (if_id_wen),
    .if_id_flush      (if_id_flush),
    .id_ex_wen        (id_ex_wen),
    .id_ex_flush      (id_ex_flush),
    .id_ex_bp_flush   (id_ex_bp_flush),
    .div_busy         (div_busy),
    .stall_cycles     (stall_cycles)
  );

  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
    id_reg_j = '0; id_reg_k = '0; id_reg_d = '0; ex_reg_d = '0;
    id_reg_j_ren = 1'b0; id_reg_k_ren = 1'b0; id_reg_d_ren = 1'b0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_div_start = 1'b0;
    ex_br_mispredict = 1'b0; mem_busy = 1'b0; bpu_invalidate = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    next_cycle();
    #1;
    n_cmp++;
    if ({ctl, id_ex_bp_flush, div_busy} !== 7'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b expected 0000000", {ctl, id_ex_bp_flush, div_busy});
    end
    n_cmp++;
    if (stall_cycles !== 16'd0) begin
      n_err++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles);
    end
    next_cycle();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== C_RUN) begin
      n_err++; $display("FAIL reset_release_ctl: got %b expected %b", ctl, C_RUN);
    end
  endtask

  task automatic test_load_use();
    // rj hit on load rd=5
    next_cycle();
    ex_valid = 1; ex_is_load = 1; ex_reg_d = 5'd5; id_reg_j = 5'd5; id_reg_j_ren = 1;
    #1;
    n_cmp++;
    if (ctl !== C_BUBBLE) begin
      n_err++; $display("FAIL lu_rj_bubble: got %b expected %b", ctl, C_BUBBLE);
    end
    next_cycle();
    #1;
    n_cmp++;
    if (ctl !== C_RUN) begin
      n_err++; $display("FAIL lu_after_bubble: got %b expected %b", ctl, C_RUN);
    end
    // r0 destination never stalls
    next_cycle();
    ex_valid = 1; ex_is_load = 1; ex_reg_d = 5'd0; id_reg_j = 5'd0; id_reg_j_ren = 1;
    #1;
    n_cmp++;
    if (ctl !== C_RUN) begin
      n_err++; $display("FAIL lu_r0: got %b expected %b", ctl, C_RUN);
    end
    // rk hit
    next_cycle();
    ex_valid = 1; ex_is_load = 1; ex_reg_d = 5'd17; id_reg_k = 5'd17; id_reg_k_ren = 1;
    #1;
    n_cmp++;
    if (ctl !== C_BUBBLE) begin
      n_err++; $display("FAIL lu_rk_bubble: got %b expected %b", ctl, C_BUBBLE);
    end
    // rd match but not read
    next_cycle();
    ex_valid = 1; ex_is_load = 1; ex_reg_d = 5'd9; id_reg_d = 5'd9; id_reg_d_ren = 0;
    #1;
    n_cmp++;
    if (ctl !== C_RUN) begin
      n_err++; $display("FAIL lu_rd_noread: got %b expected %b", ctl, C_RUN);
    end
    // rd read (store data) hits
    next_cycle();
    ex_valid = 1; ex_is_load = 1; ex_reg_d = 5'd9; id_reg_d = 5'd9; id_reg_d_ren = 1;
    #1;
    n_cmp++;
    if (ctl !== C_BUBBLE) begin
      n_err++; $display("FAIL lu_rd_read: got %b expected %b", ctl, C_BUBBLE);
    end
    // non-load producer does not stall
    next_cycle();
    ex_valid = 1; ex_is_load = 0; ex_reg_d = 5'd9; id_reg_j = 5'd9; id_reg_j_ren = 1;
    #1;
    n_cmp++;
    if (ctl !== C_RUN) begin
      n_err++; $display("FAIL lu_not_load: got %b expected %b", ctl, C_RUN);
    end
  endtask

  task automatic test_divide();
    int unsigned frz_bad = 0;
    int unsigned busy_cnt = 0;
    next_cycle();
    ex_div_start = 1;
    #1;
    n_cmp++;
    if ({ctl, div_busy} !== {C_FROZEN, 1'b0}) begin
      n_err++; $display("FAIL div_start_cycle: got %b expected %b", {ctl, div_busy}, {C_FROZEN, 1'b0});
    end
    for (int i = 1; i < 16; i++) begin
      next_cycle();
      if (i == 3) ex_div_start = 1;   // must be ignored while busy
      #1;
      if (ctl !== C_FROZEN) frz_bad++;
      if (div_busy === 1'b1) busy_cnt++;
    end
    n_cmp++;
    if (frz_bad !== 0) begin
      n_err++; $display("FAIL div_frozen_cycles: got %0d unfrozen expected 0", frz_bad);
    end
    n_cmp++;
    if (busy_cnt !== 15) begin
      n_err++; $display("FAIL div_busy_cycles: got %0d expected 15", busy_cnt);
    end
    next_cycle();
    #1;
    n_cmp++;
    if ({ctl, div_busy} !== {C_RUN, 1'b0}) begin
      n_err++; $display("FAIL div_release: got %b expected %b", {ctl, div_busy}, {C_RUN, 1'b0});
    end
    n_cmp++;
    if (stall_cycles !== 16'd16) begin
      n_err++; $display("FAIL div_stall_count: got %0d expected 16", stall_cycles);
    end
  endtask

  task automatic test_flush_vs_lu();
    next_cycle();
    ex_valid = 1; ex_is_load = 1; ex_reg_d = 5'd5; id_reg_j = 5'd5; id_reg_j_ren = 1;
    ex_br_mispredict = 1;
    #1;
    n_cmp++;
    if (ctl !== C_FLUSH) begin
      n_err++; $display("FAIL flush_beats_lu: got %b expected %b", ctl, C_FLUSH);
    end
    next_cycle();
    #1;
    n_cmp++;
    if (ctl !== C_RUN) begin
      n_err++; $display("FAIL flush_no_bubble: got %b expected %b", ctl, C_RUN);
    end
  endtask

  task automatic test_mem_busy_mispredict();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      mem_busy = 1;
      if (i == 0) ex_br_mispredict = 1;
      #1;
      n_cmp++;
      if (ctl !== C_FROZEN) begin
        n_err++; $display("FAIL mem_busy_frozen_%0d: got %b expected %b", i, ctl, C_FROZEN);
      end
    end
    next_cycle();
    #1;
    n_cmp++;
    if (ctl !== C_FLUSH) begin
      n_err++; $display("FAIL pending_flush: got %b expected %b", ctl, C_FLUSH);
    end
    next_cycle();
    #1;
    n_cmp++;
    if (ctl !== C_RUN) begin
      n_err++; $display("FAIL pending_flush_cleared: got %b expected %b", ctl, C_RUN);
    end
    n_cmp++;
    if (stall_cycles !== 16'd19) begin
      n_err++; $display("FAIL mem_stall_count: got %0d expected 19", stall_cycles);
    end
  endtask

  task automatic test_bp_flush();
    // invalidate under a 2-cycle memory wait
    next_cycle();
    mem_busy = 1; bpu_invalidate = 1;
    #1;
    n_cmp++;
    if (id_ex_bp_flush !== 1'b0) begin
      n_err++; $display("FAIL bp_registered: got %b expected 0", id_ex_bp_flush);
    end
    next_cycle();
    mem_busy = 1;
    #1;
    n_cmp++;
    if ({id_ex_bp_flush, id_ex_wen} !== 2'b10) begin
      n_err++; $display("FAIL bp_held_frozen: got %b expected 10", {id_ex_bp_flush, id_ex_wen});
    end
    next_cycle();
    #1;
    n_cmp++;
    if ({id_ex_bp_flush, id_ex_wen} !== 2'b11) begin
      n_err++; $display("FAIL bp_apply: got %b expected 11", {id_ex_bp_flush, id_ex_wen});
    end
    next_cycle();
    #1;
    n_cmp++;
    if (id_ex_bp_flush !== 1'b0) begin
      n_err++; $display("FAIL bp_cleared: got %b expected 0", id_ex_bp_flush);
    end
    // new invalidate on the clearing cycle keeps it pending
    bpu_invalidate = 1;
    next_cycle();
    bpu_invalidate = 1;
    #1;
    n_cmp++;
    if ({id_ex_bp_flush, id_ex_wen} !== 2'b11) begin
      n_err++; $display("FAIL bp_reinv_apply: got %b expected 11", {id_ex_bp_flush, id_ex_wen});
    end
    next_cycle();
    #1;
    n_cmp++;
    if (id_ex_bp_flush !== 1'b1) begin
      n_err++; $display("FAIL bp_reinv_kept: got %b expected 1", id_ex_bp_flush);
    end
    next_cycle();
    #1;
    n_cmp++;
    if (id_ex_bp_flush !== 1'b0) begin
      n_err++; $display("FAIL bp_reinv_cleared: got %b expected 0", id_ex_bp_flush);
    end
  endtask

  task automatic test_reset_mid_div();
    next_cycle();
    ex_div_start = 1;
    for (int i = 1; i < 5; i++) next_cycle();
    #1;
    n_cmp++;
    if (div_busy !== 1'b1) begin
      n_err++; $display("FAIL rstdiv_busy_before: got %b expected 1", div_busy);
    end
    next_cycle();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ctl, id_ex_bp_flush, div_busy, stall_cycles} !== 23'd0) begin
      n_err++; $display("FAIL rstdiv_outputs: got %b/%0d expected all 0", {ctl, id_ex_bp_flush, div_busy}, stall_cycles);
    end
    next_cycle();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({ctl, div_busy} !== {C_RUN, 1'b0}) begin
      n_err++; $display("FAIL rstdiv_release: got %b expected %b", {ctl, div_busy}, {C_RUN, 1'b0});
    end
    n_cmp++;
    if (stall_cycles !== 16'd0) begin
      n_err++; $display("FAIL rstdiv_stall: got %0d expected 0", stall_cycles);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_load_use();
    test_divide();
    test_flush_vs_lu();
    test_mem_busy_mispredict();
    test_bp_flush();
    test_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Drives the write-enable and flush controls of the IF/ID and ID/EX pipeline registers, plus the PC stall.
- Detects load-use hazards and inserts bubbles.
- Freezes the pipe during multi-cycle divide and data-memory waits.
- Flushes wrong-path instructions on branch mispredict, and clears stale branch-prediction bits after a BPU invalidate.

Parameters:
- DIV_CYCLES, 16, total EX-stage occupancy of a divide in cycles; legal range is 2..31.
- CNT_W, 5, width of the divide countdown counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_reg_j  in  5  rj index of the instruction in ID
- id_reg_k  in  5  rk index of the instruction in ID
- id_reg_d  in  5  rd index of the instruction in ID
- id_reg_j_ren  in  1  ID reads rj
- id_reg_k_ren  in  1  ID reads rk
- id_reg_d_ren  in  1  ID reads rd (stores, branches)
- ex_valid  in  1  EX holds a real instruction
- ex_is_load  in  1  EX instruction is a load
- ex_reg_d  in  5  EX destination register
- ex_div_start  in  1  EX holds a divide; 1-cycle pulse on its first EX cycle
- ex_br_mispredict  in  1  1-cycle pulse: EX branch resolved against its prediction
- mem_busy  in  1  data memory not ready; level signal
- bpu_invalidate  in  1  1-cycle pulse: predictor state discarded
- pc_wen  out  1  PC update enable
- if_id_wen  out  1  IF/ID write enable
- if_id_flush  out  1  IF/ID flush
- id_ex_wen  out  1  ID/EX write enable
- id_ex_flush  out  1  ID/EX flush (bubble insert)
- id_ex_bp_flush  out  1  clear branch_bp when ID/EX is written
- div_busy  out  1  divide in progress
- stall_cycles  out  16  saturating count of frozen cycles, for performance monitoring

Behaviour:
- Reset: async; state=RUN, div_cnt=0, flush_pend=0, bp_pend=0, stall_cycles=0. While rst_n=0 all outputs are 0.
- States:
  - RUN
  - DIV_BUSY
- Freeze condition: freeze = mem_busy | (state==DIV_BUSY). While frozen:
  - all *_wen=0, all flushes=0.
  - stall_cycles increments by 1 per frozen cycle, saturating at 16'hFFFF.
- Load-use hazard (lu): ex_valid & ex_is_load & ex_reg_d!=0 & ((id_reg_j_ren & id_reg_j==ex_reg_d) | (id_reg_k_ren & id_reg_k==ex_reg_d) | (id_reg_d_ren & id_reg_d==ex_reg_d)).
- Priority when not frozen:
  1. Flush (ex_br_mispredict | flush_pend): pc_wen=1, if_id_wen=1, if_id_flush=1, id_ex_wen=1, id_ex_flush=1; flush_pend cleared. Suppresses lu.
  2. lu: pc_wen=0, if_id_wen=0, id_ex_wen=1, id_ex_flush=1. Bubble lasts exactly 1 cycle, with no state.
  3. Otherwise: all wen=1, flushes=0.
- Divide:
  - In RUN with ex_div_start=1 and mem_busy=0: state->DIV_BUSY, div_cnt=DIV_CYCLES-2.
  - The start cycle itself is frozen (all wen=0).
  - In DIV_BUSY: div_cnt decrements while mem_busy=0 and holds while mem_busy=1. When div_cnt==0 and mem_busy=0, state->RUN; the following cycle advances normally.
  - Total freeze = DIV_CYCLES cycles when mem_busy stays low.
  - ex_div_start is ignored while DIV_BUSY, and it is re-sampled while mem_busy holds it pending.
- ex_br_mispredict during freeze: flush_pend set; flush applied on the first unfrozen cycle.
- Mispredict and div_start in the same cycle: illegal (same EX slot); covered by an assertion.
- id_ex_bp_flush:
  - bpu_invalidate sets bp_pend.
  - id_ex_bp_flush = bp_pend, registered.
  - bp_pend clears on the first cycle with id_ex_wen=1 after it is seen.
  - A new bpu_invalidate in the same cycle as the clear keeps bp_pend=1.
- div_busy = (state==DIV_BUSY).
- Reset asserted mid-divide returns to RUN immediately, with no flush issued.

Decomposition:
- Shared package holds:
  - state encoding (ST_RUN=1'b0, ST_DIV=1'b1)
  - DIV_CYCLES default
  - the register-index width constant (5)
- One natural sub-module: hazard_lu_detect, a purely combinational lu comparator, reusable for a later MEM-stage load-use check.

Test Plan:
- Load-use: EX={load, rd=5}, ID={rj=5, ren=1} -> one cycle with pc_wen=0, if_id_wen=0, id_ex_flush=1; next cycle all wen=1. Repeat with ex_reg_d=0 -> no stall.
- Divide, DIV_CYCLES=16: ex_div_start pulse -> id_ex_wen=0 for exactly 16 cycles, div_busy high for 15, stall_cycles=16.
- Mispredict in RUN with a simultaneous lu -> flush wins: if_id_flush=id_ex_flush=1, pc_wen=1, no bubble cycle.
- mem_busy held 3 cycles, with a mispredict pulse in cycle 1 -> wen=0 for 3 cycles, then one cycle of if_id_flush=id_ex_flush=1.
- bpu_invalidate while mem_busy=1 for 2 cycles -> id_ex_bp_flush high until the first id_ex_wen=1 cycle, then 0.
- rst_n dropped at divide cycle 5 -> outputs 0 at once; after release, state RUN, stall_cycles=0, all wen=1.
